// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the HACK data-memory arbiter.
package hack_mem_pkg;

    localparam int HACK_ADDR_W = 15;
    localparam int HACK_DATA_W = 16;

    localparam logic [14:0] HACK_KBD_ADDR = 15'h6000;
    localparam logic [14:0] HACK_SCR_BASE = 15'h4000;

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_t;
    typedef enum logic [1:0] {WIN_NONE, WIN_A, WIN_B} winner_t;
    typedef enum logic {LAST_A, LAST_B} last_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/hack_rr_pick.sv
// Combinational two-way round-robin winner select with a bounded burst lock.
module hack_rr_pick
    import hack_mem_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic       req_a,
    input  logic       req_b,
    input  owner_t     owner,
    input  last_t      last,
    input  logic [3:0] burst_cnt,
    output winner_t    winner
);

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    always_comb begin
        winner = WIN_NONE;
        // The current owner keeps the port until its burst budget runs out,
        // but only while the other side is actually waiting.
        if (owner == OWN_A && req_a && (!req_b || burst_cnt < BMAX)) begin
            winner = WIN_A;
        end else if (owner == OWN_B && req_b && (!req_a || burst_cnt < BMAX)) begin
            winner = WIN_B;
        end else if (req_a && !req_b) begin
            winner = WIN_A;
        end else if (req_b && !req_a) begin
            winner = WIN_B;
        end else if (req_a && req_b) begin
            winner = (last == LAST_B) ? WIN_A : WIN_B;
        end
    end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares the HACK data-memory port between CPU (A) and DMA/scan (B) requesters.
// Optional keyboard write protection is enabled by defining HACK_ARB_WPROT_EN.
module hack_mem_arbiter
    import hack_mem_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int ADDR_W    = HACK_ADDR_W,
    parameter int DATA_W    = HACK_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_ld,
    input  logic [DATA_W-1:0] mem_out
`ifdef HACK_ARB_WPROT_EN
    ,
    output logic              wprot_err
`endif
);

    localparam logic [ADDR_W-1:0] KBD_ADDR = ADDR_W'(HACK_KBD_ADDR);

    owner_t     owner;
    last_t      last;
    logic [3:0] burst_cnt;
    logic       rd_pend_a, rd_pend_b;
    winner_t    pick, win;
    logic       win_we, wr_block;

    hack_rr_pick #(.BURST_MAX(BURST_MAX)) u_pick (
        .req_a     (a_req),
        .req_b     (b_req),
        .owner     (owner),
        .last      (last),
        .burst_cnt (burst_cnt),
        .winner    (pick)
    );

    assign win = rst ? WIN_NONE : pick;

    always_comb begin
        a_gnt    = (win == WIN_A);
        b_gnt    = (win == WIN_B);
        mem_addr = '0;
        mem_in   = '0;
        win_we   = 1'b0;
        case (win)
            WIN_A: begin mem_addr = a_addr; mem_in = a_wdata; win_we = a_we; end
            WIN_B: begin mem_addr = b_addr; mem_in = b_wdata; win_we = b_we; end
            default: ;
        endcase
    end

`ifdef HACK_ARB_WPROT_EN
    // The handshake still completes; only the store into the keyboard range is dropped.
    assign wr_block = win_we && (mem_addr >= KBD_ADDR);
`else
    assign wr_block = 1'b0;
`endif

    assign mem_ld = win_we & ~wr_block;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= IDLE;
            last      <= LAST_B;
            burst_cnt <= 4'd0;
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            rd_pend_a <= a_gnt & ~a_we;
            rd_pend_b <= b_gnt & ~b_we;
            if (a_gnt && !a_we) a_rdata <= mem_out;
            if (b_gnt && !b_we) b_rdata <= mem_out;
            case (win)
                WIN_A: begin
                    owner     <= OWN_A;
                    last      <= LAST_A;
                    burst_cnt <= (owner == OWN_A) ? sat_inc4(burst_cnt) : 4'd1;
                end
                WIN_B: begin
                    owner     <= OWN_B;
                    last      <= LAST_B;
                    burst_cnt <= (owner == OWN_B) ? sat_inc4(burst_cnt) : 4'd1;
                end
                default: begin
                    owner     <= IDLE;
                    burst_cnt <= 4'd0;
                end
            endcase
        end
    end

    // A reset arriving while a read is in flight swallows its rvalid pulse.
    assign a_rvalid = rd_pend_a & ~rst;
    assign b_rvalid = rd_pend_b & ~rst;

`ifdef HACK_ARB_WPROT_EN
    always_ff @(posedge clk) begin
        if (rst) wprot_err <= 1'b0;
        else     wprot_err <= wr_block;
    end
`endif

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Self-checking bench for hack_mem_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.
module tb_hack_mem_arbiter;

    localparam int BMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [14:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [14:0] mem_addr;
    logic [15:0] mem_in, mem_out;
    logic        mem_ld;
`ifdef HACK_ARB_WPROT_EN
    logic        wprot_err;
`endif

    logic [15:0] mem [0:32767];
    logic [15:0] ref_mem [0:31];

    int checks = 0;
    int errors = 0;

    // reference model state: previous winner (0 none, 1 A, 2 B), run length, last granted
    int m_prev, m_run, m_last;

    always #5 clk = ~clk;

    hack_mem_arbiter #(.BURST_MAX(BMAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_ld   (mem_ld),
        .mem_out  (mem_out)
`ifdef HACK_ARB_WPROT_EN
        ,
        .wprot_err(wprot_err)
`endif
    );

    assign mem_out = mem[mem_addr];
    always @(posedge clk) if (mem_ld) mem[mem_addr] <= mem_in;

    function automatic int model_pick(input logic ra, input logic rb);
        if (m_prev == 1 && ra && (!rb || m_run < BMAX)) return 1;
        if (m_prev == 2 && rb && (!ra || m_run < BMAX)) return 2;
        if (ra && !rb) return 1;
        if (rb && !ra) return 2;
        if (ra && rb)  return (m_last == 1) ? 2 : 1;
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_prev = 0; m_run = 0; m_last = 2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0003; a_wdata = 16'hAAAA;
        b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0004;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, mem_ld} !== 3'b000) begin
            errors++; $display("FAIL reset_gnt: got %b expected 000", {a_gnt, b_gnt, mem_ld});
        end
        checks++;
        if ({a_rvalid, b_rvalid} !== 2'b00) begin
            errors++; $display("FAIL reset_rvalid: got %b expected 00", {a_rvalid, b_rvalid});
        end
        checks++;
        if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected 0000/0000", a_rdata, b_rdata);
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_read();
        mem[16'h0010] <= 16'h1234;
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, mem_ld} !== 3'b100 || mem_addr !== 15'h0010) begin
            errors++; $display("FAIL single_gnt: got gnt/ld %b addr %h expected 100 addr 0010",
                               {a_gnt, b_gnt, mem_ld}, mem_addr);
        end
        @(posedge clk); #1 a_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234 || b_gnt !== 1'b0) begin
            errors++; $display("FAIL single_rdata: got rv %b data %h bgnt %b expected 1 1234 0",
                               a_rvalid, a_rdata, b_gnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin
            errors++; $display("FAIL single_hold: got rv %b data %h expected 0 1234", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_tie_write_read();
        do_reset();
        mem[5] <= 16'h0000;
        a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0005; a_wdata = 16'hBEEF;
        b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0005;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, mem_ld} !== 3'b101 || mem_in !== 16'hBEEF) begin
            errors++; $display("FAIL tie_first: got gnt/ld %b din %h expected 101 beef",
                               {a_gnt, b_gnt, mem_ld}, mem_in);
        end
        @(posedge clk); #1 a_req = 1'b0; a_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            errors++; $display("FAIL tie_second: got %b expected 01", {a_gnt, b_gnt});
        end
        @(posedge clk); #1 b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL tie_rdata: got rv %b data %h expected 1 beef", b_rvalid, b_rdata);
        end
    endtask

    task automatic test_burst();
        int pw;
        logic [15:0] ea, eb;
        do_reset();
        pw = 0; ea = '0; eb = '0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'($urandom_range(1023));
        b_req = 1'b1; b_we = 1'b0; b_addr = 15'($urandom_range(1023));
        for (int i = 0; i < 13; i++) begin
            int w;
            if (i == 12) begin a_req = 1'b0; b_req = 1'b0; end
            w = (i == 12) ? 0 : (((i / BMAX) % 2 == 0) ? 1 : 2);
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt} !== {w == 1, w == 2}) begin
                errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, {a_gnt, b_gnt}, {w == 1, w == 2});
            end
            checks++;
            if ({a_rvalid, b_rvalid} !== {pw == 1, pw == 2} ||
                (pw == 1 && a_rdata !== ea) || (pw == 2 && b_rdata !== eb)) begin
                errors++; $display("FAIL burst_rv[%0d]: got %b %h/%h expected %b %h/%h", i,
                                   {a_rvalid, b_rvalid}, a_rdata, b_rdata, {pw == 1, pw == 2}, ea, eb);
            end
            if (w == 1) ea = mem[a_addr];
            if (w == 2) eb = mem[b_addr];
            pw = w;
            @(posedge clk); #1;
            if (w == 1) a_addr = 15'($urandom_range(1023));
            if (w == 2) b_addr = 15'($urandom_range(1023));
        end
    endtask

    task automatic test_stream_b();
        logic [15:0] scr [0:9];
        do_reset();
        for (int i = 0; i < 10; i++) begin
            scr[i] = 16'($urandom);
            mem[15'h4000 + 15'(i)] <= scr[i];
        end
        b_req = 1'b1; b_we = 1'b0; b_addr = 15'h4000;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt} !== {1'b0, i < 10}) begin
                errors++; $display("FAIL stream_gnt[%0d]: got %b expected %b", i, {a_gnt, b_gnt}, {1'b0, i < 10});
            end
            if (i > 0) begin
                checks++;
                if (b_rvalid !== 1'b1 || b_rdata !== scr[i-1]) begin
                    errors++; $display("FAIL stream_data[%0d]: got rv %b data %h expected 1 %h",
                                       i, b_rvalid, b_rdata, scr[i-1]);
                end
            end
            @(posedge clk); #1;
            if (i < 9) b_addr = b_addr + 15'd1;
            else       b_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        do_reset();
        v = 16'($urandom);
        mem[15'h0020] <= 16'h5A5A;
        mem[15'h0021] <= v;
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0020;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_gnt: got %b expected 1", a_gnt);
        end
        @(posedge clk); #1 a_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0) begin
            errors++; $display("FAIL rstmid_rvalid: got %b expected 0", a_rvalid);
        end
        @(posedge clk); #1 rst = 1'b0;
        a_req = 1'b1; b_req = 1'b1; b_we = 1'b0; a_addr = 15'h0021;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, a_rvalid} !== 3'b100) begin
            errors++; $display("FAIL rstmid_regrant: got %b expected 100", {a_gnt, b_gnt, a_rvalid});
        end
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== v) begin
            errors++; $display("FAIL rstmid_rdata: got rv %b data %h expected 1 %h", a_rvalid, a_rdata, v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic        e_rv_a, e_rv_b;
        logic [15:0] e_rd_a, e_rd_b;
        int          w;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        e_rv_a = 1'b0; e_rv_b = 1'b0; e_rd_a = '0; e_rd_b = '0; w = 0;
        for (int c = 0; c < 600; c++) begin
            logic        e_ld;
            logic [14:0] e_addr;
            logic [15:0] e_in;
            if (!a_req || w == 1) begin
                a_req = ($urandom_range(3) != 0);
                a_we = 1'($urandom_range(1)); a_addr = 15'($urandom_range(31)); a_wdata = 16'($urandom);
            end else if ($urandom_range(15) == 0) a_req = 1'b0;
            if (!b_req || w == 2) begin
                b_req = ($urandom_range(3) != 0);
                b_we = 1'($urandom_range(1)); b_addr = 15'($urandom_range(31)); b_wdata = 16'($urandom);
            end else if ($urandom_range(15) == 0) b_req = 1'b0;
            @(negedge clk);
            w = model_pick(a_req, b_req);
            e_ld   = (w == 1) ? a_we    : (w == 2) ? b_we    : 1'b0;
            e_addr = (w == 1) ? a_addr  : (w == 2) ? b_addr  : 15'h0;
            e_in   = (w == 1) ? a_wdata : (w == 2) ? b_wdata : 16'h0;
            checks++;
            if ({a_gnt, b_gnt} !== {w == 1, w == 2}) begin
                errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, {a_gnt, b_gnt}, {w == 1, w == 2});
            end
            checks++;
            if ({mem_ld, mem_addr, mem_in} !== {e_ld, e_addr, e_in}) begin
                errors++; $display("FAIL rand_port[%0d]: got %b %h %h expected %b %h %h",
                                   c, mem_ld, mem_addr, mem_in, e_ld, e_addr, e_in);
            end
            checks++;
            if (a_rvalid !== e_rv_a || a_rdata !== e_rd_a) begin
                errors++; $display("FAIL rand_a_rd[%0d]: got %b %h expected %b %h", c, a_rvalid, a_rdata, e_rv_a, e_rd_a);
            end
            checks++;
            if (b_rvalid !== e_rv_b || b_rdata !== e_rd_b) begin
                errors++; $display("FAIL rand_b_rd[%0d]: got %b %h expected %b %h", c, b_rvalid, b_rdata, e_rv_b, e_rd_b);
            end
            e_rv_a = (w == 1) && !a_we;
            e_rv_b = (w == 2) && !b_we;
            if (e_rv_a) e_rd_a = ref_mem[a_addr[4:0]];
            if (e_rv_b) e_rd_b = ref_mem[b_addr[4:0]];
            if (w == 1 && a_we) ref_mem[a_addr[4:0]] = a_wdata;
            if (w == 2 && b_we) ref_mem[b_addr[4:0]] = b_wdata;
            m_run  = (w != 0 && w == m_prev) ? m_run + 1 : ((w != 0) ? 1 : 0);
            if (w != 0) m_last = w;
            m_prev = w;
            @(posedge clk); #1;
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

`ifdef HACK_ARB_WPROT_EN
    task automatic test_wprot();
        do_reset();
        mem[15'h6000] <= 16'h0041;
        a_req = 1'b1; a_we = 1'b1; a_addr = 15'h6000; a_wdata = 16'hFFFF;
        @(negedge clk);
        checks++;
        if ({a_gnt, mem_ld, wprot_err} !== 3'b100) begin
            errors++; $display("FAIL wprot_gnt: got %b expected 100", {a_gnt, mem_ld, wprot_err});
        end
        @(posedge clk); #1 a_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wprot_err !== 1'b1 || mem[15'h6000] !== 16'h0041) begin
            errors++; $display("FAIL wprot_err: got %b kbd %h expected 1 0041", wprot_err, mem[15'h6000]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (wprot_err !== 1'b0) begin
            errors++; $display("FAIL wprot_pulse: got %b expected 0", wprot_err);
        end
    endtask
`endif

    initial begin
        do_reset();
        test_reset();
        test_single_read();
        test_tie_write_read();
        test_burst();
        test_stream_b();
        test_reset_mid();
        test_random();
`ifdef HACK_ARB_WPROT_EN
        test_wprot();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
